// File: rtl/pool_ctrl.sv
// pool_ctrl: sequencer for the 2x2/stride-2 max-pool datapath.
// Walks the IN_X x IN_Y feature buffer in window order and issues one read per
// cycle. A LAT-deep valid/index pipe then produces the output-buffer writes.
// Optional build macro: POOL_CTRL_PERF_EN adds the perf_cycles busy-cycle counter.
module pool_ctrl #(
    parameter int IN_X     = 24,
    parameter int IN_Y     = 24,
    parameter int RD_LAT   = 1,
    parameter int POOL_LAT = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 pause,
    output logic                                 rd_en,
    output logic [$clog2(IN_X*IN_Y)-1:0]         rd_addr,
    output logic                                 wr_en,
    output logic [$clog2((IN_X/2)*(IN_Y/2))-1:0] wr_addr,
    output logic                                 busy,
    output logic                                 done
`ifdef POOL_CTRL_PERF_EN
    ,
    output logic [15:0]                          perf_cycles
`endif
);

    localparam int POOL_X = IN_X / 2;
    localparam int POOL_Y = IN_Y / 2;
    localparam int N_WIN  = POOL_X * POOL_Y;
    localparam int RA_W   = $clog2(IN_X * IN_Y);
    localparam int WA_W   = $clog2(N_WIN);
    localparam int LAT    = RD_LAT + POOL_LAT;
    localparam int XW     = (POOL_X > 1) ? $clog2(POOL_X) : 1;
    localparam int YW     = $clog2(POOL_Y + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [XW-1:0]     wx;
    logic [YW-1:0]     wy;
    logic [WA_W-1:0]   k_c;
    logic              last_win_c;
    logic [LAT-1:0]    vld;
    logic [WA_W-1:0]   kpipe [LAT];
    logic              pipe_pending_c;

    // Window index and top-left pixel address from the window counters
    assign k_c        = WA_W'(wy) * WA_W'(POOL_X) + WA_W'(wx);
    assign last_win_c = (k_c == WA_W'(N_WIN - 1));
    assign rd_addr    = RA_W'(wy) * RA_W'(2 * IN_X) + RA_W'(wx) * RA_W'(2);

    // Pipe output is the write strobe and pooled element index
    assign wr_en   = vld[LAT-1];
    assign wr_addr = kpipe[LAT-1];

    // Writes still to come after the current cycle (all stages except the output)
    always_comb begin
        pipe_pending_c = 1'b0;
        for (int i = 0; i < LAT - 1; i++) begin
            pipe_pending_c = pipe_pending_c | vld[i];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (rd_en && last_win_c) state_nxt = S_DRAIN;
            S_DRAIN: if (!pipe_pending_c) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Moore status outputs; read strobe gated by pause in RUN
    always_comb begin
        rd_en = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state)
            S_RUN: begin
                rd_en = !pause;
                busy  = 1'b1;
            end
            S_DRAIN: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Window counters: clear on pass start, advance on each issued read
    always_ff @(posedge clk) begin
        if (rst) begin
            wx <= '0;
            wy <= '0;
        end else if (state == S_IDLE && start) begin
            wx <= '0;
            wy <= '0;
        end else if (rd_en) begin
            if (wx == XW'(POOL_X - 1)) begin
                wx <= '0;
                wy <= wy + YW'(1);
            end else begin
                wx <= wx + XW'(1);
            end
        end
    end

    // Valid/index pipe covering read plus pool latency; never stalled by pause
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < LAT; i++) kpipe[i] <= '0;
        end else begin
            vld[0]   <= rd_en;
            kpipe[0] <= k_c;
            for (int i = 1; i < LAT; i++) begin
                vld[i]   <= vld[i-1];
                kpipe[i] <= kpipe[i-1];
            end
        end
    end

`ifdef POOL_CTRL_PERF_EN
    // Busy-cycle counter, saturating, held after done until the next start
    always_ff @(posedge clk) begin
        if (rst)                          perf_cycles <= '0;
        else if (state == S_IDLE && start) perf_cycles <= '0;
        else if (busy && perf_cycles != 16'hFFFF) perf_cycles <= perf_cycles + 16'd1;
    end
`endif

endmodule

// File: tb/tb_pool_ctrl.sv
// tb_pool_ctrl: directed bench for pool_ctrl (default 24x24 and a 4x4/RD_LAT=2 instance).
module tb_pool_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, pause;

    logic        rd_en_a, wr_en_a, busy_a, done_a;
    logic [9:0]  rd_addr_a;
    logic [7:0]  wr_addr_a;
    logic        rd_en_b, wr_en_b, busy_b, done_b;
    logic [3:0]  rd_addr_b;
    logic [1:0]  wr_addr_b;
`ifdef POOL_CTRL_PERF_EN
    logic [15:0] perf_a, perf_b;
`endif

    pool_ctrl u_big (
        .clk(clk), .rst(rst), .start(start), .pause(pause),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
        .busy(busy_a), .done(done_a)
`ifdef POOL_CTRL_PERF_EN
        , .perf_cycles(perf_a)
`endif
    );

    pool_ctrl #(.IN_X(4), .IN_Y(4), .RD_LAT(2), .POOL_LAT(1)) u_small (
        .clk(clk), .rst(rst), .start(start), .pause(pause),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
        .busy(busy_b), .done(done_b)
`ifdef POOL_CTRL_PERF_EN
        , .perf_cycles(perf_b)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Wait (bounded) until both instances are idle
    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy_a || busy_b || done_a || done_b) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", int'(busy_a | busy_b | done_a | done_b), 0);
    endtask

    // One directed pass on instance sel (0 = 24x24/LAT2, 1 = 4x4/LAT3).
    // Cycle 0 is the cycle in which start is sampled.
    task automatic run_pass(input int sel, input int hold, input int p_lo, input int p_hi,
                            input int rst_c);
        int px, iw, nwin, lat, done_c, last_c, ri, wi, c, k;
        int rd_cyc [144];
        int g_rd, g_ra, g_wr, g_wa, g_busy, g_done, g_perf;
        bit exp_rd, exp_wr;
        px   = (sel != 0) ? 2 : 12;
        iw   = 2 * px;
        nwin = px * px;
        lat  = (sel != 0) ? 3 : 2;
        k = 0;
        c = 1;
        while (k < nwin) begin
            if (!(c >= p_lo && c <= p_hi)) begin
                rd_cyc[k] = c;
                k++;
            end
            c++;
        end
        done_c = rd_cyc[nwin-1] + lat + 1;
        if (rst_c > 0)     last_c = rst_c + 5;
        else if (hold != 0) last_c = done_c + 1;
        else               last_c = done_c + 2;
        ri = 0;
        wi = 0;
        for (int cy = 0; cy <= last_c; cy++) begin
            @(negedge clk);
            start = (cy == 0) || (hold != 0);
            pause = (cy >= p_lo && cy <= p_hi);
            rst   = (rst_c > 0 && cy == rst_c);
            #1;
            g_perf = 0;
            if (sel == 0) begin
                g_rd = int'(rd_en_a); g_ra = int'(rd_addr_a); g_wr = int'(wr_en_a);
                g_wa = int'(wr_addr_a); g_busy = int'(busy_a); g_done = int'(done_a);
`ifdef POOL_CTRL_PERF_EN
                g_perf = int'(perf_a);
`endif
            end else begin
                g_rd = int'(rd_en_b); g_ra = int'(rd_addr_b); g_wr = int'(wr_en_b);
                g_wa = int'(wr_addr_b); g_busy = int'(busy_b); g_done = int'(done_b);
`ifdef POOL_CTRL_PERF_EN
                g_perf = int'(perf_b);
`endif
            end
            if (rst_c > 0 && cy >= rst_c) begin
                if (cy > rst_c) begin
                    check($sformatf("rst_rd_en@%0d", cy), g_rd, 0);
                    check($sformatf("rst_wr_en@%0d", cy), g_wr, 0);
                    check($sformatf("rst_busy@%0d", cy), g_busy, 0);
                    check($sformatf("rst_done@%0d", cy), g_done, 0);
                end
            end else begin
                exp_rd = (ri < nwin) && (rd_cyc[ri] == cy);
                exp_wr = (wi < nwin) && (rd_cyc[wi] + lat == cy);
                check($sformatf("s%0d_rd_en@%0d", sel, cy), g_rd, int'(exp_rd));
                if (exp_rd) begin
                    check($sformatf("s%0d_rd_addr@%0d", sel, cy), g_ra,
                          2 * (ri / px) * iw + 2 * (ri % px));
                    ri++;
                end
                check($sformatf("s%0d_wr_en@%0d", sel, cy), g_wr, int'(exp_wr));
                if (exp_wr) begin
                    check($sformatf("s%0d_wr_addr@%0d", sel, cy), g_wa, wi);
                    wi++;
                end
                check($sformatf("s%0d_busy@%0d", sel, cy), g_busy, int'(cy >= 1 && cy < done_c));
                check($sformatf("s%0d_done@%0d", sel, cy), g_done, int'(cy == done_c));
`ifdef POOL_CTRL_PERF_EN
                if (cy == done_c + 1) check($sformatf("s%0d_perf", sel), g_perf, done_c - 1);
`endif
            end
        end
        if (hold != 0) begin
            // start still high: IDLE at done+1 samples it, first read of the next pass follows
            @(negedge clk);
            #1;
            check("b2b_rd_en", int'(rd_en_a), 1);
            check("b2b_rd_addr", int'(rd_addr_a), 0);
            check("b2b_busy", int'(busy_a), 1);
        end
        start = 1'b0;
        pause = 1'b0;
        rst   = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        pause = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_rd_en", int'(rd_en_a), 0);
        check("reset_wr_en", int'(wr_en_a), 0);
        check("reset_busy", int'(busy_a), 0);
        check("reset_done", int'(done_a), 0);
        check("reset_rd_addr", int'(rd_addr_a), 0);
        check("reset_wr_addr", int'(wr_addr_a), 0);
`ifdef POOL_CTRL_PERF_EN
        check("reset_perf", int'(perf_a), 0);
`endif

        // plain pass, no pause
        run_pass(0, 0, -1, -2, 0);
        wait_idle();
        // pause over cycles 10..14
        run_pass(0, 0, 10, 14, 0);
        wait_idle();
        // start held through the pass, then back-to-back second pass
        run_pass(0, 1, -1, -2, 0);
        wait_idle();
        // reset mid-pass, then a clean pass
        run_pass(0, 0, -1, -2, 50);
        wait_idle();
        run_pass(0, 0, -1, -2, 0);
        wait_idle();
        // 4x4 map with RD_LAT=2
        run_pass(1, 0, -1, -2, 0);
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
